// File: rtl/gesture_uart_rx.sv
// gesture_uart_rx: 8N1 UART receiver plus [HEADER, code, ~code] frame parser.
// Emits a validated gesture code as a one-cycle registered pulse; 8'h00 means "no new gesture".
module gesture_uart_rx #(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter int unsigned BAUD           = 115_200,
    parameter logic [7:0]  HEADER         = 8'hA5,
    parameter logic [7:0]  MAX_CODE       = 8'd3,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] gesture,
    output logic       gesture_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDLE_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BAUD_W-1:0] HALF_LAST  = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BIT_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {BitIdle, BitStart, BitData, BitStop} bit_state_e;
    typedef enum logic [1:0] {FrHunt, FrGotHdr, FrGotCode} frame_state_e;

    logic              rx_meta_q, rx_s_q, rx_prev_q;
    bit_state_e        bit_q, bit_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        data_q, data_d;
    logic              byte_stb, uart_err;

    frame_state_e      frame_q, frame_d;
    logic [7:0]        code_q, code_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [7:0]        gesture_q, gesture_d;
    logic              valid_q, err_q, err_d;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection; idle level is 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Bit FSM state, baud counter, bit counter and shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_q     <= BitIdle;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
        end else begin
            bit_q     <= bit_d;
            baud_q    <= baud_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
        end
    end

    // Bit FSM next state: half-bit wait in START aligns all later samples to mid-bit.
    always_comb begin
        bit_d     = bit_q;
        baud_d    = baud_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        byte_stb  = 1'b0;
        uart_err  = 1'b0;
        unique case (bit_q)
            BitIdle: begin
                baud_d    = '0;
                bit_cnt_d = '0;
                if (rx_prev_q && !rx_s_q) bit_d = BitStart;
            end
            BitStart: begin
                if (baud_q == HALF_LAST) begin
                    baud_d = '0;
                    // A high line at mid-start is a glitch: drop silently.
                    bit_d  = rx_s_q ? BitIdle : BitData;
                end
            end
            BitData: begin
                if (baud_q == BIT_LAST) begin
                    baud_d    = '0;
                    data_d    = {rx_s_q, data_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) bit_d = BitStop;
                end
            end
            BitStop: begin
                if (baud_q == BIT_LAST) begin
                    baud_d   = '0;
                    byte_stb = rx_s_q;
                    uart_err = !rx_s_q;
                    // Leave at mid-stop so an immediately following start bit is caught.
                    bit_d    = BitIdle;
                end
            end
            default: bit_d = BitIdle;
        endcase
    end

    // Frame FSM state, latched code, idle counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_q   <= FrHunt;
            code_q    <= '0;
            idle_q    <= '0;
            gesture_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            frame_q   <= frame_d;
            code_q    <= code_d;
            idle_q    <= idle_d;
            gesture_q <= gesture_d;
            valid_q   <= (gesture_d != 8'h00);
            err_q     <= err_d;
        end
    end

    // Frame FSM next state: a received byte takes priority over a coincident timeout.
    always_comb begin
        frame_d   = frame_q;
        code_d    = code_q;
        idle_d    = idle_q;
        gesture_d = 8'h00;
        err_d     = 1'b0;
        if (uart_err) begin
            err_d   = 1'b1;
            frame_d = FrHunt;
        end else if (byte_stb) begin
            idle_d = '0;
            unique case (frame_q)
                FrHunt: begin
                    if (data_q == HEADER) frame_d = FrGotHdr;
                end
                FrGotHdr: begin
                    if (data_q != HEADER) begin
                        code_d  = data_q;
                        frame_d = FrGotCode;
                    end
                end
                FrGotCode: begin
                    if (data_q == ~code_q && code_q != 8'h00 && code_q <= MAX_CODE) begin
                        gesture_d = code_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    frame_d = (data_q == HEADER) ? FrGotHdr : FrHunt;
                end
                default: frame_d = FrHunt;
            endcase
        end else if (frame_q != FrHunt && idle_q != IDLE_LIMIT) begin
            // Counter stops at the limit; the frame is abandoned on the same edge.
            idle_d = idle_q + 1'b1;
            if (idle_d == IDLE_LIMIT) begin
                err_d   = 1'b1;
                frame_d = FrHunt;
            end
        end
    end

    assign gesture       = gesture_q;
    assign gesture_valid = valid_q;
    assign frame_err     = err_q;
    assign rx_busy       = (bit_q != BitIdle);

endmodule

// File: tb/tb_gesture_uart_rx.sv
// Directed bench for gesture_uart_rx at 10 clocks per bit, timeout 300.
module tb_gesture_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] gesture;
    logic       gesture_valid;
    logic       frame_err;
    logic       rx_busy;

    gesture_uart_rx #(
        .CLK_HZ        (1_000_000),
        .BAUD          (100_000),
        .HEADER        (8'hA5),
        .MAX_CODE      (8'd3),
        .TIMEOUT_CYCLES(300)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .gesture      (gesture),
        .gesture_valid(gesture_valid),
        .frame_err    (frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Event monitor, sampled on the falling edge away from the active edge.
    int         cyc = 0;
    int         g_cnt = 0, e_cnt = 0, wide_cnt = 0, bad_cnt = 0, rise_cnt = 0;
    int         g_cyc = 0, e_cyc = 0, fall_cyc = 0;
    logic [7:0] last_g = 8'h00;
    logic       busy_p = 1'b0, gv_p = 1'b0;

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        busy_p <= rx_busy;
        gv_p   <= gesture_valid;
        if (reset) begin
            if (gesture_valid) begin
                g_cnt  <= g_cnt + 1;
                last_g <= gesture;
                g_cyc  <= cyc;
            end
            if (gesture_valid && gv_p) wide_cnt <= wide_cnt + 1;
            if (frame_err) begin
                e_cnt <= e_cnt + 1;
                e_cyc <= cyc;
            end
            if ((gesture_valid != (gesture != 8'h00)) || (frame_err && gesture_valid))
                bad_cnt <= bad_cnt + 1;
            if (busy_p && !rx_busy) fall_cyc <= cyc;
            if (!busy_p && rx_busy) rise_cnt <= rise_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; leaves the line high after the stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (10) @(negedge clk);
        end
        rx = stop_bit;
        repeat (10) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic settle();
        repeat (30) @(negedge clk);
    endtask

    int         g0, e0, r0, fall0;
    logic [7:0] fd;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_gesture", {24'h0, gesture}, 32'h0);
        check("rst_valid", {31'h0, gesture_valid}, 32'h0);
        check("rst_ferr", {31'h0, frame_err}, 32'h0);
        check("rst_busy", {31'h0, rx_busy}, 32'h0);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        // 1: good frame; the gesture appears on the first cycle rx_busy is low after FE
        g0 = g_cnt; e0 = e_cnt;
        send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'hFE, 1'b1);
        settle();
        check("t1_gcount", g_cnt - g0, 1);
        check("t1_code", {24'h0, last_g}, 32'h01);
        check("t1_ferr", e_cnt - e0, 0);
        check("t1_latency", g_cyc - fall_cyc, 0);
        check("t1_after", {24'h0, gesture}, 32'h0);

        // 2: bad checksum, then a good frame
        g0 = g_cnt; e0 = e_cnt;
        send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        settle();
        check("t2_bad_g", g_cnt - g0, 0);
        check("t2_bad_e", e_cnt - e0, 1);
        g0 = g_cnt; e0 = e_cnt;
        send_byte(8'hA5, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'hFC, 1'b1);
        settle();
        check("t2_good_g", g_cnt - g0, 1);
        check("t2_code", {24'h0, last_g}, 32'h03);
        check("t2_good_e", e_cnt - e0, 0);

        // 3: out-of-range code, then junk and a doubled header before a good frame
        g0 = g_cnt; e0 = e_cnt;
        send_byte(8'hA5, 1'b1); send_byte(8'h07, 1'b1); send_byte(8'hF8, 1'b1);
        settle();
        check("t3_range_g", g_cnt - g0, 0);
        check("t3_range_e", e_cnt - e0, 1);
        g0 = g_cnt; e0 = e_cnt;
        send_byte(8'h55, 1'b1); send_byte(8'hA5, 1'b1); send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1); send_byte(8'hFD, 1'b1);
        settle();
        check("t3_resync_g", g_cnt - g0, 1);
        check("t3_code", {24'h0, last_g}, 32'h02);
        check("t3_resync_e", e_cnt - e0, 0);

        // 4: timeout 300 clocks after the header's first idle cycle, then parser is hunting
        g0 = g_cnt; e0 = e_cnt;
        send_byte(8'hA5, 1'b1);
        repeat (400) @(negedge clk);
        fall0 = fall_cyc;
        check("t4_to_e", e_cnt - e0, 1);
        check("t4_to_cyc", e_cyc - fall0, 300);
        send_byte(8'h01, 1'b1); send_byte(8'hFE, 1'b1);
        settle();
        check("t4_hunt_g", g_cnt - g0, 0);
        check("t4_hunt_e", e_cnt - e0, 1);

        // 5: start-bit glitch, then a header with a broken stop bit
        g0 = g_cnt; e0 = e_cnt; r0 = rise_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_glitch_busy", r0 == rise_cnt ? 32'h0 : 32'h1, 32'h1);
        check("t5_glitch_idle", {31'h0, rx_busy}, 32'h0);
        check("t5_glitch_e", e_cnt - e0, 0);
        send_byte(8'hA5, 1'b0);
        settle();
        check("t5_stop_e", e_cnt - e0, 1);
        send_byte(8'h01, 1'b1); send_byte(8'hFE, 1'b1);
        settle();
        check("t5_no_hdr_g", g_cnt - g0, 0);
        check("t5_no_hdr_e", e_cnt - e0, 1);

        // 6: reset in the middle of the checksum discards the frame
        g0 = g_cnt; e0 = e_cnt;
        send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1);
        fd = 8'hFD;
        rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = fd[i];
            repeat (10) @(negedge clk);
        end
        rx = fd[3];
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_rst_gesture", {24'h0, gesture}, 32'h0);
        check("t6_rst_valid", {31'h0, gesture_valid}, 32'h0);
        check("t6_rst_ferr", {31'h0, frame_err}, 32'h0);
        check("t6_rst_busy", {31'h0, rx_busy}, 32'h0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 4; i < 8; i++) begin
            rx = fd[i];
            repeat (10) @(negedge clk);
        end
        rx = 1'b1;
        repeat (10) @(negedge clk);
        settle();
        check("t6_partial_g", g_cnt - g0, 0);
        check("t6_partial_e", e_cnt - e0, 0);
        send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'hFD, 1'b1);
        settle();
        check("t6_good_g", g_cnt - g0, 1);
        check("t6_code", {24'h0, last_g}, 32'h02);

        // Invariants over the whole run
        check("pulse_width", wide_cnt, 0);
        check("valid_consistency", bad_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
